// File: rtl/uart_packet_tx.sv
// Packet transmitter: buffers host payload bytes, then serialises SOF, LEN, payload, CHK
// as 12-bit frames (start, d[7:0] MSB first, even parity, two stops) on a registered serial line.
module uart_packet_tx #(
    parameter int          CLKS_PER_BAUD = 15259,
    parameter int          MAX_LEN       = 20,
    parameter logic [7:0]  SOF_BYTE      = 8'hA5
) (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       send,
    output logic       ser_out,
    output logic       busy,
    output logic       done,
    output logic [4:0] buf_count,
    output logic [2:0] err_code
);

    localparam int BW = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SOF, S_LEN, S_PAY, S_CHK} pkt_state_t;

    pkt_state_t      state_q, state_n;
    logic [BW-1:0]   baud_q, baud_n;
    logic [3:0]      bit_q, bit_n;
    logic [7:0]      byte_q, byte_n;
    logic [4:0]      idx_q, idx_n, nxt_idx;
    logic [7:0]      len_q, len_n;
    logic [7:0]      chk_q, chk_n;
    logic [7:0]      xor_q, xor_n;
    logic [4:0]      count_q, count_n;
    logic [2:0]      err_q, err_n;
    logic            ser_q, ser_n;
    logic            done_q, done_n;
    logic            buf_we;
    logic            last_tick;
    logic [11:0]     cur_frame;
    logic [7:0]      buf_mem [MAX_LEN];

    function automatic logic [11:0] frame_of(input logic [7:0] b);
        return {1'b0, b, ^b, 2'b11};
    endfunction

    // Payload storage is not reset; buf_count alone defines what is valid.
    always_ff @(posedge ref_clk) begin
        if (buf_we) buf_mem[count_q] <= wr_data;
    end

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            chk_q   <= '0;
            xor_q   <= '0;
            count_q <= '0;
            err_q   <= '0;
            ser_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            byte_q  <= byte_n;
            idx_q   <= idx_n;
            len_q   <= len_n;
            chk_q   <= chk_n;
            xor_q   <= xor_n;
            count_q <= count_n;
            err_q   <= err_n;
            ser_q   <= ser_n;
            done_q  <= done_n;
        end
    end

    assign cur_frame = frame_of(byte_q);
    assign last_tick = (baud_q == BW'(CLKS_PER_BAUD - 1));
    assign nxt_idx   = idx_q + 5'd1;

    always_comb begin
        state_n = state_q;
        baud_n  = baud_q;
        bit_n   = bit_q;
        byte_n  = byte_q;
        idx_n   = idx_q;
        len_n   = len_q;
        chk_n   = chk_q;
        xor_n   = xor_q;
        count_n = count_q;
        err_n   = err_q;
        ser_n   = ser_q;
        done_n  = 1'b0;
        buf_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ser_n = 1'b1;
                if (send) begin
                    // A write coinciding with send is always dropped and flagged.
                    if (count_q != 5'd0) begin
                        state_n = S_SOF;
                        byte_n  = SOF_BYTE;
                        bit_n   = '0;
                        baud_n  = '0;
                        ser_n   = 1'b0;
                        len_n   = {3'b000, count_q};
                        chk_n   = {3'b000, count_q} ^ xor_q;
                        err_n   = wr_en ? 3'd3 : 3'd0;
                    end else begin
                        err_n   = wr_en ? 3'd3 : 3'd1;
                    end
                end else if (wr_en) begin
                    if (count_q < 5'(MAX_LEN)) begin
                        buf_we  = 1'b1;
                        count_n = count_q + 5'd1;
                        xor_n   = xor_q ^ wr_data;
                    end else begin
                        err_n   = 3'd2;
                    end
                end
            end
            default: begin
                if (wr_en) err_n = 3'd3;
                if (!last_tick) begin
                    baud_n = baud_q + BW'(1);
                end else begin
                    baud_n = '0;
                    if (bit_q != 4'd11) begin
                        bit_n = bit_q + 4'd1;
                        ser_n = cur_frame[4'd10 - bit_q];
                    end else begin
                        // Frame complete: next byte's start bit follows with no gap.
                        bit_n = '0;
                        ser_n = 1'b0;
                        case (state_q)
                            S_SOF: begin
                                state_n = S_LEN;
                                byte_n  = len_q;
                            end
                            S_LEN: begin
                                state_n = S_PAY;
                                idx_n   = '0;
                                byte_n  = buf_mem[0];
                            end
                            S_PAY: begin
                                if (idx_q == len_q[4:0] - 5'd1) begin
                                    state_n = S_CHK;
                                    byte_n  = chk_q;
                                end else begin
                                    idx_n   = nxt_idx;
                                    byte_n  = buf_mem[nxt_idx];
                                end
                            end
                            default: begin
                                state_n = S_IDLE;
                                ser_n   = 1'b1;
                                done_n  = 1'b1;
                                count_n = '0;
                                xor_n   = '0;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    assign ser_out   = ser_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign buf_count = count_q;
    assign err_code  = err_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Self-checking bench for uart_packet_tx: a queue-based packet model predicts the
// serial bit stream, error codes and handshake outputs cycle by cycle.
module tb_uart_packet_tx;

    localparam int CPB  = 4;
    localparam int MAXL = 20;
    localparam int FCYC = 12 * CPB;

    logic       ref_clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       send;
    logic       ser_out;
    logic       busy;
    logic       done;
    logic [4:0] buf_count;
    logic [2:0] err_code;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_q[$];
    logic [11:0] exp_q[$];
    logic [2:0]  exp_err;

    uart_packet_tx #(.CLKS_PER_BAUD(CPB), .MAX_LEN(MAXL), .SOF_BYTE(8'hA5)) dut (
        .ref_clk   (ref_clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .send      (send),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done),
        .buf_count (buf_count),
        .err_code  (err_code)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
        if (model_q.size() < MAXL) model_q.push_back(b);
        else exp_err = 3'd2;
    endtask

    function automatic logic [11:0] make_frame(input logic [7:0] b);
        return {1'b0, b, ^b, 2'b11};
    endfunction

    task automatic build_frames();
        logic [7:0] chk;
        exp_q.delete();
        chk = 8'(model_q.size());
        exp_q.push_back(make_frame(8'hA5));
        exp_q.push_back(make_frame(8'(model_q.size())));
        foreach (model_q[i]) begin
            exp_q.push_back(make_frame(model_q[i]));
            chk ^= model_q[i];
        end
        exp_q.push_back(make_frame(chk));
    endtask

    // Sends the modelled packet and checks every cycle of it; optionally injects
    // a write+send at cycle inject_at or an asynchronous reset at cycle abort_at.
    task automatic run_packet(input int inject_at, input int abort_at);
        int          n_cyc;
        logic [11:0] fr;
        build_frames();
        n_cyc   = exp_q.size() * FCYC;
        send    = 1'b1;
        tick();
        send    = 1'b0;
        exp_err = 3'd0;
        for (int t = 0; t < n_cyc; t++) begin
            fr = exp_q[t / FCYC];
            check_eq("ser_out", ser_out, fr[11 - ((t / CPB) % 12)]);
            check_eq("busy", busy, 1);
            check_eq("done_early", done, 0);
            if (t == abort_at) begin
                reset = 1'b1;
                #1;
                check_eq("abort_ser_out", ser_out, 1);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_buf_count", buf_count, 0);
                check_eq("abort_done", done, 0);
                tick();
                reset = 1'b0;
                model_q.delete();
                exp_err = 3'd0;
                return;
            end
            if (t == inject_at) begin
                wr_en   = 1'b1;
                wr_data = 8'hEE;
                send    = 1'b1;
                exp_err = 3'd3;
            end
            tick();
            wr_en = 1'b0;
            send  = 1'b0;
        end
        check_eq("done_pulse", done, 1);
        check_eq("end_busy", busy, 0);
        check_eq("end_ser_out", ser_out, 1);
        check_eq("end_buf_count", buf_count, 0);
        check_eq("end_err_code", err_code, exp_err);
        model_q.delete();
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        send    = 1'b0;
        exp_err = 3'd0;
        repeat (3) tick();
        check_eq("rst_ser_out", ser_out, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_buf_count", buf_count, 0);
        check_eq("rst_err_code", err_code, 0);
        reset = 1'b0;
        tick();

        // Single byte packet: 4 frames, done 192 cycles after send.
        write_byte(8'h3C);
        check_eq("t1_buf_count", buf_count, 1);
        run_packet(-1, -1);
        tick();
        check_eq("t1_done_one_cycle", done, 0);

        // Full buffer plus overflow write.
        for (int i = 0; i < MAXL; i++) write_byte(8'(i));
        write_byte(8'hFF);
        check_eq("t2_err_overflow", err_code, exp_err);
        check_eq("t2_buf_count", buf_count, 20);
        run_packet(-1, -1);

        // Send with empty buffer is ignored and flagged.
        send = 1'b1;
        tick();
        send = 1'b0;
        exp_err = 3'd1;
        for (int i = 0; i < 10; i++) begin
            check_eq("t3_ser_out", ser_out, 1);
            check_eq("t3_busy", busy, 0);
            tick();
        end
        check_eq("t3_err_empty", err_code, exp_err);

        // Write and send during transmission: packet unchanged, no second packet.
        write_byte(8'($urandom_range(0, 255)));
        write_byte(8'($urandom_range(0, 255)));
        run_packet(60, -1);
        for (int i = 0; i < 60; i++) begin
            tick();
            check_eq("t4_idle_ser_out", ser_out, 1);
            check_eq("t4_idle_busy", busy, 0);
        end
        check_eq("t4_err_busy", err_code, 3);

        // Reset at bit 5 of the third frame, then a fresh 1-byte packet.
        for (int i = 0; i < 3; i++) write_byte(8'($urandom_range(0, 255)));
        run_packet(-1, 2 * FCYC + 5 * CPB + 2);
        check_eq("t5_post_rst_err", err_code, 0);
        check_eq("t5_post_rst_count", buf_count, 0);
        write_byte(8'($urandom_range(0, 255)));
        check_eq("t5_new_count", buf_count, 1);
        run_packet(-1, -1);

        // Back-to-back: refill during done cycle, send the cycle after.
        write_byte(8'h5A);
        run_packet(-1, -1);
        check_eq("t6_gap_ser_out", ser_out, 1);
        write_byte(8'($urandom_range(0, 255)));
        check_eq("t6_gap2_ser_out", ser_out, 1);
        check_eq("t6_buf_count", buf_count, 1);
        run_packet(-1, -1);

        // Random packets.
        repeat (4) begin
            int len;
            len = $urandom_range(1, MAXL);
            for (int i = 0; i < len; i++) write_byte(8'($urandom));
            check_eq("rnd_buf_count", buf_count, 32'(len));
            run_packet(-1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
